// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: the queue entry handed to decode
// and the NOP word used for fetches beyond the end of instruction memory.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries between the PC/imem side and decode.
// Flush wins over push/pop so a redirect discards everything in flight.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ENTRY_W-1:0] i_wr_entry,
    output logic [ENTRY_W-1:0] o_rd_entry,
    output logic [1:0]         o_count
);

    fetch_entry_t r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    assign o_rd_entry = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    // A push and pop together when full is safe: the slot written is the one
    // being popped, and the read pointer moves past it on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= fetch_entry_t'(i_wr_entry);
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory, range-checks
// the fetch and queues {pc, pc+4, instr, fault} toward decode with valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_fault,
    output logic        misalign_err
);

    import fetch_pkg::*;

    logic [31:0]        r_pc;
    logic               r_misalign;
    logic               w_in_range;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_count;
    fetch_entry_t       w_wr_entry;
    fetch_entry_t       w_head;
    logic [ENTRY_W-1:0] w_head_bits;

    // 33-bit compare so a PC near 2^32 cannot wrap into range.
    assign w_in_range = ({1'b0, r_pc} + 33'd3) < 33'(IMEM_BYTES);

    assign id_valid = (w_count != 2'd0);
    assign w_pop    = id_valid && id_ready;
    assign w_push   = !redirect_valid && ((w_count < 2'd2) || w_pop);

    always_comb begin
        w_wr_entry          = '0;
        w_wr_entry.pc       = r_pc;
        w_wr_entry.pc_plus4 = r_pc + 32'd4;
        w_wr_entry.instr    = w_in_range ? imem_instr : NOP_INSTR;
        w_wr_entry.fault    = !w_in_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                r_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    fetch_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .i_wr_entry (w_wr_entry),
        .o_rd_entry (w_head_bits),
        .o_count    (w_count)
    );

    assign w_head       = fetch_entry_t'(w_head_bits);
    assign imem_addr    = r_pc;
    assign id_pc        = w_head.pc;
    assign id_pc_plus4  = w_head.pc_plus4;
    assign id_instr     = w_head.instr;
    assign id_fault     = w_head.fault;
    assign misalign_err = r_misalign;

endmodule
